// File: rtl/rsa_rfid_pkg.sv
// ============================================================================
// rsa_rfid_pkg - shared constants and packer state encoding for the RSA RFID datapath
// Rev 1.0
// ============================================================================
`default_nettype none

package rsa_rfid_pkg;

  localparam int FIFO_DATA_W        = 8;
  localparam int DEF_WORD_BYTES     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } pack_state_t;

endpackage

`default_nettype wire

// File: rtl/pack_idle_timer.sv
// ============================================================================
// pack_idle_timer - counts idle cycles of a partial word; expire at TIMEOUT_CYCLES-1
// Rev 1.0
// ============================================================================
`default_nettype none

module pack_idle_timer
  import rsa_rfid_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Saturates at the terminal value so expire stays asserted until cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick && (count != C_LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == C_LAST);

endmodule

`default_nettype wire

// File: rtl/fifo_byte_packer.sv
// ============================================================================
// fifo_byte_packer - drains a show-ahead byte FIFO into MSB-first operand words.
// Optional partial-word flush on idle timeout: define PACK_FLUSH_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module fifo_byte_packer
  import rsa_rfid_pkg::*;
#(
  parameter int WORD_BYTES     = DEF_WORD_BYTES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [FIFO_DATA_W-1:0]                    fifo_data,
  input  logic                                      fifo_empty,
  output logic                                      fifo_rd_en,
  output logic [FIFO_DATA_W*WORD_BYTES-1:0]         word_out,
  output logic                                      word_valid,
  input  logic                                      word_ready,
  output logic [$clog2(WORD_BYTES+1)-1:0]           valid_bytes,
  output logic                                      busy
);

  localparam int WORD_W = FIFO_DATA_W * WORD_BYTES;
  localparam int CNT_W  = $clog2(WORD_BYTES + 1);
  localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(WORD_BYTES - 1);
  localparam logic [CNT_W-1:0] C_FULL     = CNT_W'(WORD_BYTES);

  if ((WORD_BYTES < 2) || (WORD_BYTES > 16) || (TIMEOUT_CYCLES < 2)) begin : g_param_check
    $error("fifo_byte_packer: WORD_BYTES must be 2..16 and TIMEOUT_CYCLES >= 2");
  end

  pack_state_t       state;
  logic [WORD_W-1:0] shift;
  logic [CNT_W-1:0]  byte_cnt;
  logic [WORD_W-1:0] shift_next;
  logic              last_byte;

  assign fifo_rd_en = (state == ST_COLLECT) && !fifo_empty;
  assign shift_next = {shift[WORD_W-FIFO_DATA_W-1:0], fifo_data};
  assign last_byte  = fifo_rd_en && (byte_cnt == C_LAST_IDX);
  assign busy       = (byte_cnt != '0) || word_valid;

`ifdef PACK_FLUSH_EN
  logic              idle_tick;
  logic              idle_expire;
  logic              flush;
  logic [WORD_W-1:0] flush_word;

  // A pop clears the timer, so a byte arriving at expiry always wins.
  assign idle_tick  = (state == ST_COLLECT) && fifo_empty && (byte_cnt != '0);
  assign flush      = idle_tick && idle_expire;
  assign flush_word = shift << (FIFO_DATA_W * (WORD_BYTES - int'(byte_cnt)));

  pack_idle_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!idle_tick),
    .tick   (idle_tick),
    .expire (idle_expire)
  );
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_COLLECT;
      shift       <= '0;
      byte_cnt    <= '0;
      word_out    <= '0;
      valid_bytes <= '0;
      word_valid  <= 1'b0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (fifo_rd_en) begin
            shift <= shift_next;
            if (last_byte) begin
              word_out    <= shift_next;
              valid_bytes <= C_FULL;
              word_valid  <= 1'b1;
              byte_cnt    <= '0;
              state       <= ST_HOLD;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
`ifdef PACK_FLUSH_EN
          else if (flush) begin
            word_out    <= flush_word;
            valid_bytes <= byte_cnt;
            word_valid  <= 1'b1;
            byte_cnt    <= '0;
            state       <= ST_HOLD;
          end
`endif
        end
        ST_HOLD: begin
          if (word_ready) begin
            word_valid <= 1'b0;
            state      <= ST_COLLECT;
          end
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_byte_packer.sv
// ============================================================================
// tb_fifo_byte_packer - randomized and directed checks of fifo_byte_packer against a queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fifo_byte_packer;

  localparam int WB  = 4;
  localparam int TO  = 16;
  localparam int WW  = 8 * WB;
  localparam int VBW = $clog2(WB + 1);

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [7:0]     fifo_data = 8'h00;
  logic           fifo_empty = 1'b1;
  logic           fifo_rd_en;
  logic [WW-1:0]  word_out;
  logic           word_valid;
  logic           word_ready = 1'b0;
  logic [VBW-1:0] valid_bytes;
  logic           busy;

  always #5 clk = ~clk;

  fifo_byte_packer #(
    .WORD_BYTES     (WB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_data   (fifo_data),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .valid_bytes (valid_bytes),
    .busy        (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Upstream FIFO contents and the model's view of the packer.
  logic [7:0]    q[$];
  logic [7:0]    part[$];
  bit            m_have;
  logic [WW-1:0] m_word;
  int            m_vb;
  int            m_idle;
  int            force_gap;

  logic [WW-1:0] last_word;
  int            last_vb;
  int            rd_cnt, valid_cyc, words_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] pack_part();
    logic [WW-1:0] w = '0;
    for (int i = 0; i < part.size(); i++) w[WW-1-8*i -: 8] = part[i];
    return w;
  endfunction

  task automatic model_reset();
    part.delete();
    m_have = 1'b0;
    m_word = '0;
    m_vb   = 0;
    m_idle = 0;
  endtask

  task automatic step(input int ready_pct, input int gap_pct);
    bit gap;
    @(negedge clk);
    word_ready = ($urandom_range(99) < ready_pct);
    gap = (force_gap > 0) || ($urandom_range(99) < gap_pct);
    if (force_gap > 0) force_gap--;
    fifo_empty = (q.size() == 0) || gap;
    fifo_data  = fifo_empty ? 8'($urandom) : q[0];
    #1;
    chk("rd_en",       64'(fifo_rd_en),  64'(!m_have && !fifo_empty));
    chk("word_valid",  64'(word_valid),  64'(m_have));
    chk("word_out",    64'(word_out),    64'(m_word));
    chk("valid_bytes", 64'(valid_bytes), 64'(m_vb));
    chk("busy",        64'(busy),        64'((part.size() != 0) || m_have));
    if (word_valid && word_ready) begin
      last_word = word_out;
      last_vb   = int'(valid_bytes);
    end
    if (fifo_rd_en) rd_cnt++;
    if (word_valid) valid_cyc++;
    // Model advance for the coming rising edge.
    if (m_have) begin
      if (word_ready) begin
        m_have = 1'b0;
        words_acc++;
      end
    end else if (!fifo_empty) begin
      part.push_back(q.pop_front());
      m_idle = 0;
      if (part.size() == WB) begin
        m_word = pack_part();
        m_vb   = WB;
        m_have = 1'b1;
        part.delete();
      end
    end else begin
`ifdef PACK_FLUSH_EN
      if (part.size() > 0) begin
        if (m_idle == TO - 1) begin
          m_word = pack_part();
          m_vb   = part.size();
          m_have = 1'b1;
          part.delete();
          m_idle = 0;
        end else begin
          m_idle++;
        end
      end
`endif
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    fifo_empty = 1'b1;
    #1;
    model_reset();
    q.delete();
    chk("rst_word_valid", 64'(word_valid), 64'd0);
    chk("rst_busy",       64'(busy),       64'd0);
    chk("rst_word_out",   64'(word_out),   64'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    force_gap = 0;
    rd_cnt = 0; valid_cyc = 0; words_acc = 0;
    last_word = '0; last_vb = 0;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_word_out",    64'(word_out),    64'd0);
    chk("reset_word_valid",  64'(word_valid),  64'd0);
    chk("reset_valid_bytes", 64'(valid_bytes), 64'd0);
    chk("reset_busy",        64'(busy),        64'd0);
    chk("reset_rd_en",       64'(fifo_rd_en),  64'd0);
    rst = 1'b1;

    repeat (20) step(100, 0);
    chk("empty_busy",  64'(busy),       64'd0);
    chk("empty_valid", 64'(word_valid), 64'd0);

    rd_cnt = 0; valid_cyc = 0;
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    repeat (8) step(100, 0);
    chk("basic_word",      64'(last_word), 64'h11223344);
    chk("basic_vb",        64'(last_vb),   64'd4);
    chk("basic_pops",      64'(rd_cnt),    64'd4);
    chk("basic_valid_cyc", 64'(valid_cyc), 64'd1);

    rd_cnt = 0;
    q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    repeat (15) step(0, 0);
    chk("stall_word",  64'(word_out),   64'hA0A1A2A3);
    chk("stall_valid", 64'(word_valid), 64'd1);
    chk("stall_pops",  64'(rd_cnt),     64'd4);
    repeat (10) step(100, 0);
    chk("stall_second_word", 64'(last_word), 64'hA4A5A6A7);

    q = '{8'hAA, 8'hBB};
    repeat (2) step(100, 0);
    do_reset();
    q = '{8'h01, 8'h02, 8'h03, 8'h04};
    repeat (8) step(100, 0);
    chk("midreset_word", 64'(last_word), 64'h01020304);

`ifdef PACK_FLUSH_EN
    q = '{8'hBE, 8'hEF};
    repeat (25) step(100, 0);
    chk("flush_word", 64'(last_word), 64'hBEEF0000);
    chk("flush_vb",   64'(last_vb),   64'd2);

    words_acc = 0;
    q = '{8'h51};
    step(100, 0);
    q = '{8'h52, 8'h53, 8'h54};
    force_gap = TO - 1;
    repeat (25) step(100, 0);
    chk("expiry_word",  64'(last_word), 64'h51525354);
    chk("expiry_vb",    64'(last_vb),   64'd4);
    chk("expiry_count", 64'(words_acc), 64'd1);
`endif

    for (int c = 0; c < 3000; c++) begin
      if ((q.size() < 12) && ($urandom_range(1) == 1)) q.push_back(8'($urandom));
      if ((c % 200) == 100) force_gap = $urandom_range(TO + 4, TO - 4);
      step(70, 30);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
